// File: rtl/decred_result_collector_if.sv
// Signal bundle between the result collector, the shared hash-macro read port
// and the SPI-side result FIFO reader.
interface decred_result_collector_if #(
    parameter int NUM_MACROS = 4,
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  scan_en_i;
    logic [NUM_MACROS-1:0] data_available_i;
    logic [NUM_MACROS-1:0] macro_rd_select_o;
    logic [5:0]            hash_addr_o;
    logic [7:0]            data_from_hash_i;
    logic                  fifo_rd_en_i;
    logic [7:0]            fifo_data_o;
    logic                  fifo_empty_o;
    logic [CNT_W-1:0]      fifo_count_o;
    logic                  busy_o;
    logic                  result_irq_o;

    modport master (
        input  scan_en_i, data_available_i, data_from_hash_i, fifo_rd_en_i,
        output macro_rd_select_o, hash_addr_o, fifo_data_o, fifo_empty_o,
               fifo_count_o, busy_o, result_irq_o
    );

    modport slave (
        output scan_en_i, data_available_i, data_from_hash_i, fifo_rd_en_i,
        input  macro_rd_select_o, hash_addr_o, fifo_data_o, fifo_empty_o,
               fifo_count_o, busy_o, result_irq_o
    );
endinterface

// File: rtl/decred_result_collector.sv
// Round-robin read-out engine that copies pending hash-macro results into a byte FIFO.
// Optional feature macro: DECRED_RESULT_TAG_EN (prefix each record with a macro-index tag byte).
module decred_result_collector #(
    parameter int         NUM_MACROS       = 4,
    parameter logic [5:0] RESULT_BASE_ADDR = 6'h20,
    parameter int         RESULT_BYTES     = 4,
    parameter int         FIFO_DEPTH       = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    decred_result_collector_if.master bus
);
`ifdef DECRED_RESULT_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif
    localparam int REC   = RESULT_BYTES + (TAG_EN ? 1 : 0);
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            sel_q, sel_d;
    logic [3:0]            rr_q, rr_d;
    logic [3:0]            idx_q, idx_d;
    logic [NUM_MACROS-1:0] rd_sel_q, rd_sel_d;
    logic [5:0]            addr_q, addr_d;
    logic                  busy_q;
    logic                  irq_q;
    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [15:0]           avail_wide_s;
    logic [4:0]            cand_s;
    logic [3:0]            pick_sel_s;
    logic                  pick_found_s;
    logic [CNT_W-1:0]      free_s;
    logic                  start_s;
    logic                  last_s;
    logic                  push_s;
    logic                  pop_s;
    logic [7:0]            push_data_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Round-robin search: first pending macro at or after rr_q, wrapping modulo NUM_MACROS.
    always_comb begin
        avail_wide_s = 16'(bus.data_available_i);
        pick_found_s = 1'b0;
        pick_sel_s   = 4'd0;
        cand_s       = 5'd0;
        for (int i = 0; i < NUM_MACROS; i++) begin
            cand_s = {1'b0, rr_q} + 5'(i);
            if (cand_s >= 5'(NUM_MACROS)) begin
                cand_s = cand_s - 5'(NUM_MACROS);
            end else begin
                cand_s = cand_s;
            end
            if (!pick_found_s && avail_wide_s[cand_s[3:0]]) begin
                pick_found_s = 1'b1;
                pick_sel_s   = cand_s[3:0];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // A service only starts when a whole record is guaranteed to fit.
    assign free_s  = CNT_W'(FIFO_DEPTH) - count_q;
    assign start_s = bus.scan_en_i && pick_found_s && (free_s >= CNT_W'(REC));
    assign last_s  = (idx_q == 4'(RESULT_BYTES - 1));
    assign pop_s   = bus.fifo_rd_en_i && (count_q != '0);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) state_d = ST_READ;
                else         state_d = ST_IDLE;
            end
            ST_READ: begin
                if (last_s) state_d = ST_DRAIN;
                else        state_d = ST_READ;
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath and bus outputs; read data lags its address by one cycle.
    always_comb begin
        sel_d       = sel_q;
        rr_d        = rr_q;
        idx_d       = idx_q;
        rd_sel_d    = rd_sel_q;
        addr_d      = addr_q;
        push_s      = 1'b0;
        push_data_s = bus.data_from_hash_i;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    sel_d    = pick_sel_s;
                    idx_d    = 4'd0;
                    rd_sel_d = NUM_MACROS'(1) << pick_sel_s;
                    addr_d   = RESULT_BASE_ADDR;
                end else begin
                    rd_sel_d = '0;
                    addr_d   = 6'd0;
                end
            end
            ST_READ: begin
                if (idx_q != 4'd0) begin
                    push_s = 1'b1;
                end else if (TAG_EN) begin
                    push_s      = 1'b1;
                    push_data_s = {4'h0, sel_q};
                end else begin
                    push_s = 1'b0;
                end
                if (last_s) begin
                    rd_sel_d = '0;
                    addr_d   = 6'd0;
                end else begin
                    addr_d = addr_q + 6'd1;
                    idx_d  = idx_q + 4'd1;
                end
            end
            ST_DRAIN: begin
                push_s = 1'b1;
                rr_d   = (sel_q == 4'(NUM_MACROS - 1)) ? 4'd0 : sel_q + 4'd1;
            end
            default: begin
                rd_sel_d = '0;
                addr_d   = 6'd0;
            end
        endcase
    end

    // FIFO occupancy; simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // State, bus and FIFO control registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            sel_q    <= 4'd0;
            rr_q     <= 4'd0;
            idx_q    <= 4'd0;
            rd_sel_q <= '0;
            addr_q   <= 6'd0;
            busy_q   <= 1'b0;
            irq_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_q     <= rr_d;
            idx_q    <= idx_d;
            rd_sel_q <= rd_sel_d;
            addr_q   <= addr_d;
            busy_q   <= (state_d != ST_IDLE);
            irq_q    <= (count_q >= CNT_W'(REC));
            wr_ptr_q <= push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            rd_ptr_q <= pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_data_s;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign bus.macro_rd_select_o = rd_sel_q;
    assign bus.hash_addr_o       = addr_q;
    assign bus.fifo_data_o       = mem_q[rd_ptr_q];
    assign bus.fifo_empty_o      = (count_q == '0);
    assign bus.fifo_count_o      = count_q;
    assign bus.busy_o            = busy_q;
    assign bus.result_irq_o      = irq_q;
endmodule
